// File: rtl/ulpi_link_if.sv
// ULPI link-side front end: bus turnaround, RX CMD / data split, PHY register-write
// sequencer with dir-abort retry, and post-reset startup wait.
module ulpi_link_if #(
  parameter int unsigned STARTUP_CYCLES = 16,
  parameter int unsigned REG_RETRY_MAX  = 4,
  parameter bit          CMD_FILTER     = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  output logic       phy_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_active_o,
  output logic       rx_error_o,
  output logic [1:0] linestate_o,
  output logic       rx_cmd_valid_o,
  input  logic       reg_wr_i,
  input  logic [5:0] reg_addr_i,
  input  logic [7:0] reg_data_i,
  output logic       reg_busy_o,
  output logic       reg_done_o,
  output logic       reg_err_o
);

  localparam int unsigned SW = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned RW = $clog2(REG_RETRY_MAX + 2);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_STP, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic          dir_q;
  logic [SW-1:0] start_cnt_q;
  logic          ready_d;
  logic [5:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [RW-1:0] retry_q;
  logic [7:0]    last_cmd_q;
  logic          last_vld_q;
  logic          accept;
  logic          link_owns_bus;
  logic [7:0]    data_d;
  logic          stp_d, done_d, err_d, busy_d;

  // Combinational only from dir so the link releases the bus in the same cycle dir rises.
  assign ulpi_data_oe_o = ~ulpi_dir_i & ~dir_q;
  assign link_owns_bus  = ulpi_data_oe_o;
  assign accept         = (state_q == S_IDLE) & ~reg_busy_o & reg_wr_i;
  assign ready_d        = phy_ready_o | (start_cnt_q == SW'(STARTUP_CYCLES));

  // Startup wait and dir history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_q       <= 1'b0;
      start_cnt_q <= '0;
      phy_ready_o <= 1'b0;
    end else begin
      dir_q <= ulpi_dir_i;
      if (start_cnt_q != SW'(STARTUP_CYCLES)) start_cnt_q <= start_cnt_q + SW'(1);
      phy_ready_o <= ready_d;
    end
  end

  // RX path: runs whenever the PHY owns the bus, independent of the write sequencer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o      <= 8'h00;
      rx_valid_o     <= 1'b0;
      rx_active_o    <= 1'b0;
      rx_error_o     <= 1'b0;
      linestate_o    <= 2'b00;
      rx_cmd_valid_o <= 1'b0;
      last_cmd_q     <= 8'h00;
      last_vld_q     <= 1'b0;
    end else begin
      rx_valid_o     <= 1'b0;
      rx_error_o     <= 1'b0;
      rx_cmd_valid_o <= 1'b0;
      if (ulpi_dir_i & dir_q) begin
        if (ulpi_nxt_i) begin
          rx_data_o  <= ulpi_data_i;
          rx_valid_o <= 1'b1;
        end else begin
          linestate_o    <= ulpi_data_i[1:0];
          last_cmd_q     <= ulpi_data_i;
          last_vld_q     <= 1'b1;
          rx_cmd_valid_o <= ~(CMD_FILTER && last_vld_q && (ulpi_data_i == last_cmd_q));
          case (ulpi_data_i[5:4])
            2'b01:   rx_active_o <= 1'b1;
            2'b11:   rx_error_o  <= 1'b1;
            default: rx_active_o <= 1'b0;
          endcase
        end
      end else if (ulpi_dir_i & ~dir_q & ulpi_nxt_i) begin
        rx_active_o <= 1'b1;
      end else if (~ulpi_dir_i & dir_q) begin
        rx_active_o <= 1'b0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer next state; dir high in CMD/DATA aborts even if nxt is also high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CMD;
      S_CMD: begin
        if (ulpi_dir_i)                       state_d = S_WAIT;
        else if (ulpi_nxt_i && link_owns_bus) state_d = S_DATA;
      end
      S_DATA: begin
        if (ulpi_dir_i)                       state_d = S_WAIT;
        else if (ulpi_nxt_i && link_owns_bus) state_d = S_STP;
      end
      S_STP: state_d = S_IDLE;
      S_WAIT: begin
        if (!ulpi_dir_i && !dir_q)
          state_d = (retry_q <= RW'(REG_RETRY_MAX)) ? S_CMD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs, computed for the next state and registered below.
  always_comb begin
    data_d = 8'h00;
    stp_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_d)
      S_CMD:   data_d = {2'b10, (state_q == S_IDLE) ? reg_addr_i : addr_q};
      S_DATA:  data_d = wdata_q;
      S_STP:   stp_d  = 1'b1;
      default: data_d = 8'h00;
    endcase
    if (state_q == S_STP) done_d = 1'b1;
    if (state_q == S_WAIT && state_d == S_IDLE) begin
      done_d = 1'b1;
      err_d  = 1'b1;
    end
    busy_d = ~(ready_d & (state_d == S_IDLE));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ulpi_data_o <= 8'h00;
      ulpi_stp_o  <= 1'b0;
      reg_done_o  <= 1'b0;
      reg_err_o   <= 1'b0;
      reg_busy_o  <= 1'b1;
      addr_q      <= 6'h00;
      wdata_q     <= 8'h00;
      retry_q     <= '0;
    end else begin
      ulpi_data_o <= data_d;
      ulpi_stp_o  <= stp_d;
      reg_done_o  <= done_d;
      reg_err_o   <= err_d;
      reg_busy_o  <= busy_d;
      if (accept) begin
        addr_q  <= reg_addr_i;
        wdata_q <= reg_data_i;
        retry_q <= '0;
      end else if ((state_q == S_CMD || state_q == S_DATA) && ulpi_dir_i) begin
        retry_q <= retry_q + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ulpi_link_if.sv
// Directed bench for ulpi_link_if: table-driven RX vectors plus hand sequences for
// startup, register write, abort/retry exhaustion and asynchronous reset mid-write.
module tb_ulpi_link_if;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ulpi_data_i = 8'h00;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       dir = 1'b0;
  logic       nxt = 1'b0;
  logic       stp;
  logic       phy_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error, rx_cmd_valid;
  logic [1:0] linestate;
  logic       reg_wr = 1'b0;
  logic [5:0] reg_addr = 6'h00;
  logic [7:0] reg_data = 8'h00;
  logic       reg_busy, reg_done, reg_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ulpi_link_if #(.STARTUP_CYCLES(16), .REG_RETRY_MAX(2), .CMD_FILTER(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o), .ulpi_data_oe_o(ulpi_data_oe),
    .ulpi_dir_i(dir), .ulpi_nxt_i(nxt), .ulpi_stp_o(stp),
    .phy_ready_o(phy_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_active_o(rx_active),
    .rx_error_o(rx_error), .linestate_o(linestate), .rx_cmd_valid_o(rx_cmd_valid),
    .reg_wr_i(reg_wr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .reg_busy_o(reg_busy), .reg_done_o(reg_done), .reg_err_o(reg_err)
  );

  typedef struct {
    logic       dir;
    logic       nxt;
    logic [7:0] data;
    logic       oe;
    logic       valid;
    logic [7:0] rxd;
    logic       act;
    logic       cmdv;
    logic [1:0] ls;
    logic       err;
  } vec_t;

  vec_t tbl [16];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic startup_check(input string tag);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("%s_ready_e%0d", tag, i), phy_ready, (i >= 17));
      chk1($sformatf("%s_busy_e%0d", tag, i), reg_busy, (i < 17));
      chk1($sformatf("%s_nodone_e%0d", tag, i), reg_done, 1'b0);
    end
  endtask

  int   phases;
  int   stp_seen;
  logic got_done;
  logic [7:0] prev_bus;

  initial begin
    //           dir   nxt   data   oe    vld   rxd    act   cmdv  ls     err
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 2'b01, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 2'b01, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 2'b10, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 2'b10, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b0, 2'b10, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 2'b10, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 2'b10, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0, 2'b10, 1'b0};

    // Reset values, then startup wait.
    #1 rst = 1'b1;
    #12;
    chk8("rst_bus", ulpi_data_o, 8'h00);
    chk1("rst_stp", stp, 1'b0);
    chk1("rst_ready", phy_ready, 1'b0);
    chk1("rst_busy", reg_busy, 1'b1);
    chk1("rst_done", reg_done, 1'b0);
    chk1("rst_active", rx_active, 1'b0);
    chk8("rst_ls", 8'(linestate), 8'h00);
    @(negedge clk) rst = 1'b0;
    startup_check("start");

    // RX path vectors.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dir = tbl[i].dir; nxt = tbl[i].nxt; ulpi_data_i = tbl[i].data;
      #1;
      chk1($sformatf("v%0d_oe", i), ulpi_data_oe, tbl[i].oe);
      @(posedge clk); #1;
      chk1($sformatf("v%0d_valid", i), rx_valid, tbl[i].valid);
      chk8($sformatf("v%0d_rxdata", i), rx_data, tbl[i].rxd);
      chk1($sformatf("v%0d_active", i), rx_active, tbl[i].act);
      chk1($sformatf("v%0d_cmdvalid", i), rx_cmd_valid, tbl[i].cmdv);
      chk8($sformatf("v%0d_linestate", i), 8'(linestate), 8'(tbl[i].ls));
      chk1($sformatf("v%0d_rxerror", i), rx_error, tbl[i].err);
      chk8($sformatf("v%0d_bus", i), ulpi_data_o, 8'h00);
    end

    // Register write: nxt on 2nd CMD cycle and 1st DATA cycle.
    @(negedge clk);
    reg_wr = 1'b1; reg_addr = 6'h0A; reg_data = 8'h45;
    @(posedge clk); #1;
    chk8("wr_cmd1", ulpi_data_o, 8'h8A);
    chk1("wr_cmd1_busy", reg_busy, 1'b1);
    chk1("wr_cmd1_oe", ulpi_data_oe, 1'b1);
    @(negedge clk) reg_wr = 1'b0;
    @(posedge clk); #1;
    chk8("wr_cmd2", ulpi_data_o, 8'h8A);
    @(negedge clk) nxt = 1'b1;
    @(posedge clk); #1;
    chk8("wr_data", ulpi_data_o, 8'h45);
    chk1("wr_data_stp", stp, 1'b0);
    @(posedge clk); #1;
    chk8("wr_stp_bus", ulpi_data_o, 8'h00);
    chk1("wr_stp", stp, 1'b1);
    chk1("wr_stp_done", reg_done, 1'b0);
    @(negedge clk) nxt = 1'b0;
    @(posedge clk); #1;
    chk1("wr_done", reg_done, 1'b1);
    chk1("wr_err", reg_err, 1'b0);
    chk1("wr_stp_end", stp, 1'b0);
    chk1("wr_busy_end", reg_busy, 1'b0);
    @(posedge clk); #1;
    chk1("wr_done_pulse", reg_done, 1'b0);

    // Abort in DATA on every attempt until retries run out.
    phases = 0; stp_seen = 0; got_done = 1'b0; prev_bus = 8'h00;
    @(negedge clk);
    reg_wr = 1'b1; reg_addr = 6'h15; reg_data = 8'h99;
    for (int c = 0; c < 60 && !got_done; c++) begin
      @(posedge clk); #1;
      if (ulpi_data_o == 8'h95 && prev_bus != 8'h95) phases++;
      prev_bus = ulpi_data_o;
      if (stp) stp_seen++;
      if (reg_done) begin
        got_done = 1'b1;
        chk1("retry_err", reg_err, 1'b1);
      end
      @(negedge clk);
      reg_wr = 1'b0;
      if (dir) begin
        dir = 1'b0; nxt = 1'b0;
      end else if (ulpi_data_o == 8'h95) begin
        nxt = 1'b1;
      end else if (ulpi_data_o == 8'h99) begin
        dir = 1'b1; nxt = 1'b0;
      end else begin
        nxt = 1'b0;
      end
    end
    dir = 1'b0; nxt = 1'b0;
    chk1("retry_done_seen", got_done, 1'b1);
    chk8("retry_cmd_phases", 8'(phases), 8'd3);
    chk8("retry_no_stp", 8'(stp_seen), 8'd0);
    repeat (3) @(posedge clk);
    #1 chk1("retry_idle_busy", reg_busy, 1'b0);

    // Asynchronous reset while the sequencer sits in DATA.
    @(negedge clk);
    reg_wr = 1'b1; reg_addr = 6'h01; reg_data = 8'h55;
    @(negedge clk);
    reg_wr = 1'b0; nxt = 1'b1;
    @(posedge clk); #1;
    chk8("mid_data_bus", ulpi_data_o, 8'h55);
    @(negedge clk);
    nxt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk8("arst_bus", ulpi_data_o, 8'h00);
    chk1("arst_stp", stp, 1'b0);
    chk1("arst_busy", reg_busy, 1'b1);
    chk1("arst_ready", phy_ready, 1'b0);
    chk1("arst_done", reg_done, 1'b0);
    @(negedge clk) rst = 1'b0;
    startup_check("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ulpi_link_if.md
Name: ulpi_link_if

Overview:
- Parametrised ULPI link-side front end for the sniffer core. Runs in the 60 MHz PHY clock domain.
- Owns bus turnaround and output-enable generation.
- Splits the received stream into RX CMD updates and USB data bytes.
- Runs a PHY register-write sequencer with abort and retry, plus a post-reset startup wait.

Parameters:
- STARTUP_CYCLES, 16: clk_i cycles after reset release before the PHY is considered ready; minimum 1.
- REG_RETRY_MAX, 4: register-write attempts allowed after a dir abort before failing with an error.
- CMD_FILTER, 1: when 1, suppress an RX CMD pulse whose byte equals the last reported RX CMD.

Ports:
- clk_i  in  1  ULPI 60 MHz clock.
- rst_i  in  1  Asynchronous, active-high reset.
- ulpi_data_i  in  8  ULPI data from the IO buffer.
- ulpi_data_o  out  8  ULPI data to the IO buffer.
- ulpi_data_oe_o  out  1  Link drives ulpi_data when 1.
- ulpi_dir_i  in  1  PHY direction.
- ulpi_nxt_i  in  1  PHY next.
- ulpi_stp_o  out  1  ULPI stop.
- phy_ready_o  out  1  Startup wait complete.
- rx_data_o  out  8  Received USB byte.
- rx_valid_o  out  1  One-cycle strobe qualifying rx_data_o.
- rx_active_o  out  1  Packet reception in progress.
- rx_error_o  out  1  One-cycle strobe on RxError.
- linestate_o  out  2  Last reported LineState.
- rx_cmd_valid_o  out  1  One-cycle strobe on a new RX CMD.
- reg_wr_i  in  1  Register-write request; sampled only when reg_busy_o is 0.
- reg_addr_i  in  6  PHY register address.
- reg_data_i  in  8  PHY register write data.
- reg_busy_o  out  1  Sequencer not accepting requests.
- reg_done_o  out  1  One-cycle strobe when a write completes or fails.
- reg_err_o  out  1  Valid with reg_done_o; 1 = retries exhausted.

Behaviour:
- Reset values: all outputs 0, ulpi_data_o = 8'h00, reg_busy_o = 1, linestate_o = 2'b00. Reset mid-write abandons the transfer silently: no reg_done_o, and stp is not driven.
- Startup:
  - Counter counts STARTUP_CYCLES after rst_i deasserts.
  - phy_ready_o rises on the following edge and stays high until reset.
  - reg_busy_o = 1 until phy_ready_o is high and the FSM is IDLE.
- Turnaround:
  - dir_q is ulpi_dir_i registered.
  - A turnaround cycle is any cycle where ulpi_dir_i != dir_q. No data is sampled or driven in a turnaround cycle.
  - ulpi_data_oe_o = ~ulpi_dir_i & ~dir_q. This is the only combinational path from dir, so the link never contends with the PHY.
- RX path (dir_i & dir_q, not turnaround), all outputs registered with 1-cycle latency:
  - nxt=1: rx_data_o <= data; rx_valid_o pulses.
  - nxt=0: data is an RX CMD.
    - linestate_o <= data[1:0].
    - data[5:4]: 01 sets rx_active_o; 11 pulses rx_error_o and keeps rx_active_o; 00 or 10 clears rx_active_o.
    - rx_cmd_valid_o pulses unless CMD_FILTER=1 and the byte equals the last reported RX CMD.
  - Turnaround with dir rising and nxt=1: rx_active_o sets.
  - dir falling: rx_active_o clears.
- Register write FSM, states IDLE, CMD, DATA, STP, WAIT:
  - IDLE: ulpi_data_o = 8'h00 (NOOP). On accepted reg_wr_i, latch addr/data, clear the retry count, go to CMD.
  - CMD: only when oe=1, drive {2'b10, addr}. When nxt=1, go to DATA.
  - DATA: drive data. When nxt=1, go to STP.
  - STP: ulpi_stp_o=1, data 8'h00, for 1 cycle. Then reg_done_o=1, reg_err_o=0, go to IDLE.
  - Abort: ulpi_dir_i high in CMD or DATA aborts the attempt and increments the retry count, then goes to WAIT.
  - WAIT: stays until dir_i and dir_q are both 0. Then goes to CMD if the retry count <= REG_RETRY_MAX; otherwise pulses reg_done_o with reg_err_o=1 and goes to IDLE.
  - A simultaneous nxt=1 and dir rise counts as an abort.
  - The RX path runs independently of the FSM at all times.

Test Plan:
- Reset then idle, STARTUP_CYCLES=16 → phy_ready_o rises on the 17th edge after reset release; reg_busy_o falls the same cycle.
- Write addr 6'h0A, data 8'h45; PHY asserts nxt on the 2nd CMD cycle and the 1st DATA cycle → bus shows 8'h8A, 8'h45, stp pulse with 8'h00, then reg_done_o=1, reg_err_o=0.
- dir rises with nxt=1 at turnaround, then bytes 8'hA5, 8'h3C with nxt=1, then dir falls:
  - 2 rx_valid_o pulses with the correct bytes.
  - rx_active_o high from the cycle after turnaround until 1 cycle after dir falls.
  - ulpi_data_oe_o=0 throughout.
- RX CMDs 8'h01, 8'h01, 8'h31 with CMD_FILTER=1 → 2 rx_cmd_valid_o pulses; linestate_o ends 2'b01; one rx_error_o pulse.
- dir asserted during DATA in every attempt, REG_RETRY_MAX=2:
  - 3 CMD phases appear on the bus.
  - Then reg_done_o=1 with reg_err_o=1.
  - No stp is driven.
- rst_i asserted mid-DATA → all outputs return to reset values immediately (asynchronous), no reg_done_o, and the startup wait restarts.
